demux_tdm_4ch: RTL and testbench

- Registered 1-to-4 demultiplexer. It is the counterpart of the 4:1 selector: one input word stream is distributed to four output channels.
- Each output channel holds a one-entry buffer with a valid/ready handshake.
- The target channel comes either from the select input (addressed mode) or from an internal rotating pointer (round-robin mode).
- It sits between a single serial producer and four independent consumers.

---
 rtl/demux_tdm_4ch.sv | 39 +++
 tb/tb_demux_tdm_4ch.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/demux_tdm_4ch.sv
// demux_tdm_4ch: registered 1-to-4 demultiplexer with per-channel one-entry buffers,
// addressed by s or steered by a round-robin pointer.
module demux_tdm_4ch #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [W-1:0]   d,
   input  logic [1:0]     s,
   input  logic           mode,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [4*W-1:0] y,
   output logic [3:0]     out_valid,
   input  logic [3:0]     out_ready,
   output logic [1:0]     ptr,
   output logic [7:0]     xfer_cnt
);
   logic [1:0] tgt;
   logic       acc;
   logic [3:0] fill;
   assign tgt      = mode ? ptr : s;
   assign in_ready = !out_valid[tgt] | out_ready[tgt];
   assign acc      = in_valid & in_ready;
   assign fill     = acc ? 4'b0001 << tgt : 4'b0000;
   // a refill in the same cycle as a drain keeps the channel valid
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         y         <= '0;
         out_valid <= '0;
         ptr       <= '0;
         xfer_cnt  <= '0;
      end else begin
         out_valid <= (out_valid & ~out_ready) | fill;
         if (acc) y[tgt*W +: W] <= d;
         if (acc) xfer_cnt <= xfer_cnt + 8'd1;
         if (acc & mode) ptr <= ptr + 2'd1;
      end
endmodule

// File: tb/tb_demux_tdm_4ch.sv
// tb_demux_tdm_4ch: directed self-checking bench for demux_tdm_4ch.
module tb_demux_tdm_4ch;
   localparam int W = 4;
   logic           clk = 0;
   logic           rst_n = 0;
   logic [W-1:0]   d = '0;
   logic [1:0]     s = '0;
   logic           mode = 0;
   logic           in_valid = 0;
   logic           in_ready;
   logic [4*W-1:0] y;
   logic [3:0]     out_valid;
   logic [3:0]     out_ready = '0;
   logic [1:0]     ptr;
   logic [7:0]     xfer_cnt;
   int n_cmp = 0;
   int n_err = 0;

   demux_tdm_4ch #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .d(d), .s(s), .mode(mode), .in_valid(in_valid),
      .in_ready(in_ready), .y(y), .out_valid(out_valid), .out_ready(out_ready),
      .ptr(ptr), .xfer_cnt(xfer_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] ch(input int k);
      return y[k*W +: W];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0; d = 4'hF; in_valid = 1; mode = 0; s = 0; out_ready = 0;
      tick(); tick();
      n_cmp++; if (y !== '0) begin n_err++; $display("FAIL reset_y got %h want 0", y); end
      n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL reset_out_valid got %b want 0000", out_valid); end
      n_cmp++; if (ptr !== 2'd0) begin n_err++; $display("FAIL reset_ptr got %0d want 0", ptr); end
      n_cmp++; if (xfer_cnt !== 8'd0) begin n_err++; $display("FAIL reset_xfer got %0d want 0", xfer_cnt); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      in_valid = 0;
      #1 rst_n = 1;
      tick();
      n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL release_out_valid got %b want 0000", out_valid); end
      n_cmp++; if (xfer_cnt !== 8'd0) begin n_err++; $display("FAIL release_xfer got %0d want 0", xfer_cnt); end
   endtask

   task automatic test_addressed();
      mode = 0; d = 4'b0101; in_valid = 1; out_ready = 0;
      for (int k = 0; k < 4; k++) begin
         s = 2'(k);
         tick();
         n_cmp++; if (ch(k) !== 4'b0101) begin n_err++; $display("FAIL addr_y%0d got %h want 5", k, ch(k)); end
         n_cmp++; if (out_valid[k] !== 1'b1) begin n_err++; $display("FAIL addr_valid%0d got %b want 1", k, out_valid[k]); end
      end
      in_valid = 0;
      n_cmp++; if (out_valid !== 4'b1111) begin n_err++; $display("FAIL addr_out_valid got %b want 1111", out_valid); end
      n_cmp++; if (xfer_cnt !== 8'd4) begin n_err++; $display("FAIL addr_xfer got %0d want 4", xfer_cnt); end
      n_cmp++; if (ptr !== 2'd0) begin n_err++; $display("FAIL addr_ptr got %0d want 0", ptr); end
   endtask

   task automatic test_backpressure();
      s = 2; d = 4'hA; in_valid = 1; out_ready = 0;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      tick();
      n_cmp++; if (ch(2) !== 4'h5) begin n_err++; $display("FAIL bp_y2_hold got %h want 5", ch(2)); end
      n_cmp++; if (xfer_cnt !== 8'd4) begin n_err++; $display("FAIL bp_xfer_hold got %0d want 4", xfer_cnt); end
      out_ready = 4'b0100;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_pass_in_ready got %b want 1", in_ready); end
      tick();
      in_valid = 0; out_ready = 0;
      n_cmp++; if (ch(2) !== 4'hA) begin n_err++; $display("FAIL bp_y2_new got %h want a", ch(2)); end
      n_cmp++; if (out_valid !== 4'b1111) begin n_err++; $display("FAIL bp_out_valid got %b want 1111", out_valid); end
      n_cmp++; if (xfer_cnt !== 8'd5) begin n_err++; $display("FAIL bp_xfer got %0d want 5", xfer_cnt); end
   endtask

   task automatic test_round_robin();
      in_valid = 0; out_ready = 4'hF;
      tick();
      n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL rr_drain got %b want 0000", out_valid); end
      mode = 1; in_valid = 1;
      for (int i = 1; i <= 5; i++) begin
         d = 4'(i);
         n_cmp++; if (ptr !== 2'((i - 1) % 4)) begin n_err++; $display("FAIL rr_ptr%0d got %0d want %0d", i, ptr, (i - 1) % 4); end
         tick();
         n_cmp++; if (ch((i - 1) % 4) !== 4'(i)) begin n_err++; $display("FAIL rr_y%0d got %h want %h", i, ch((i - 1) % 4), i); end
         n_cmp++; if (out_valid !== 4'b0001 << ((i - 1) % 4)) begin n_err++; $display("FAIL rr_valid%0d got %b", i, out_valid); end
      end
      in_valid = 0;
      n_cmp++; if (ptr !== 2'd1) begin n_err++; $display("FAIL rr_ptr_end got %0d want 1", ptr); end
      n_cmp++; if (xfer_cnt !== 8'd10) begin n_err++; $display("FAIL rr_xfer got %0d want 10", xfer_cnt); end
   endtask

   task automatic test_mode_switch();
      rst_n = 0; #1 rst_n = 1;
      mode = 1; out_ready = 4'hF; in_valid = 1;
      d = 4'h6; tick();
      d = 4'h7; tick();
      n_cmp++; if (ptr !== 2'd2) begin n_err++; $display("FAIL ms_ptr_rr got %0d want 2", ptr); end
      mode = 0; s = 0; d = 4'h8; tick();
      n_cmp++; if (ptr !== 2'd2) begin n_err++; $display("FAIL ms_ptr_hold got %0d want 2", ptr); end
      n_cmp++; if (ch(0) !== 4'h8) begin n_err++; $display("FAIL ms_y0 got %h want 8", ch(0)); end
      mode = 1; d = 4'h9; tick();
      in_valid = 0;
      n_cmp++; if (ch(2) !== 4'h9) begin n_err++; $display("FAIL ms_y2 got %h want 9", ch(2)); end
      n_cmp++; if (out_valid !== 4'b0100) begin n_err++; $display("FAIL ms_out_valid got %b want 0100", out_valid); end
      n_cmp++; if (ptr !== 2'd3) begin n_err++; $display("FAIL ms_ptr_end got %0d want 3", ptr); end
      n_cmp++; if (xfer_cnt !== 8'd4) begin n_err++; $display("FAIL ms_xfer got %0d want 4", xfer_cnt); end
   endtask

   task automatic test_async_reset();
      in_valid = 0; out_ready = 4'hF;
      tick();
      mode = 0; out_ready = 0; in_valid = 1; d = 4'hC;
      s = 0; tick();
      s = 1; tick();
      s = 3; tick();
      in_valid = 0;
      n_cmp++; if (out_valid !== 4'b1011) begin n_err++; $display("FAIL ar_pre_valid got %b want 1011", out_valid); end
      #2 rst_n = 0;
      #1;
      n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL ar_out_valid got %b want 0000", out_valid); end
      n_cmp++; if (y !== '0) begin n_err++; $display("FAIL ar_y got %h want 0", y); end
      n_cmp++; if (xfer_cnt !== 8'd0) begin n_err++; $display("FAIL ar_xfer got %0d want 0", xfer_cnt); end
      n_cmp++; if (ptr !== 2'd0) begin n_err++; $display("FAIL ar_ptr got %0d want 0", ptr); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ar_in_ready got %b want 1", in_ready); end
      in_valid = 1;
      tick();
      n_cmp++; if (xfer_cnt !== 8'd0 || out_valid !== 4'b0000) begin n_err++; $display("FAIL ar_no_accept got xfer %0d valid %b want 0 0000", xfer_cnt, out_valid); end
      in_valid = 0;
      rst_n = 1;
   endtask

   initial begin
      test_reset();
      test_addressed();
      test_backpressure();
      test_round_robin();
      test_mode_switch();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
